// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// rtl/serial_subtractor_half_subtractor.sv - one-bit half subtractor (x - y)
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one bit per clock
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    // per-bit full subtract built from two half subtractors
    logic d0;
    logic bo0;
    logic d_bit;
    logic bo1;
    logic br_next;

    half_subtractor u_hs_ab (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .d  (d0),
        .bo (bo0)
    );

    half_subtractor u_hs_br (
        .x  (d0),
        .y  (br),
        .d  (d_bit),
        .bo (bo1)
    );

    assign br_next = bo0 | bo1;

    // FSM, operand shifters, borrow, counter and registered outputs.
    // Result bits are shifted into the top of the minuend register as its
    // low bits are consumed, so after WIDTH steps a_sr holds the difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= {d_bit, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        diff   <= {d_bit, a_sr[WIDTH-1:1]};
                        borrow <= br_next;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8 and 16
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        sel16;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  diff8;
    logic        borrow8;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] diff16;
    logic        borrow16;

    logic        busy_m;
    logic        done_m;
    logic [31:0] diff_m;
    logic        borrow_m;

    int vectors;
    int miscompares;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk    (clk),
        .rst    (rst),
        .start  (start16),
        .a      (a16),
        .b      (b16),
        .busy   (busy16),
        .done   (done16),
        .diff   (diff16),
        .borrow (borrow16)
    );

    always #5 clk = ~clk;

    always_comb begin
        busy_m   = sel16 ? busy16   : busy8;
        done_m   = sel16 ? done16   : done8;
        diff_m   = sel16 ? {16'd0, diff16} : {24'd0, diff8};
        borrow_m = sel16 ? borrow16 : borrow8;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s, input logic [31:0] av, input logic [31:0] bv);
        if (sel16) begin
            start16 = s;
            a16     = av[15:0];
            b16     = bv[15:0];
        end else begin
            start8 = s;
            a8     = av[7:0];
            b8     = bv[7:0];
        end
    endtask

    // one operation; operands are scrambled while busy to prove they are not re-sampled
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] dv, output logic brv,
                         output int lat, output int bcnt, output bit stable);
        logic [31:0] prev;
        bit          seen;
        @(negedge clk);
        prev = diff_m;
        drive(1'b1, av, bv);
        @(negedge clk);
        drive(1'b0, $urandom, $urandom);
        lat    = 1;
        bcnt   = 0;
        stable = 1'b1;
        seen   = 1'b0;
        while (!seen && lat <= 60) begin
            if (busy_m) bcnt++;
            if (done_m) begin
                seen = 1'b1;
            end else begin
                if (diff_m !== prev) stable = 1'b0;
                @(negedge clk);
                lat++;
                drive(1'b0, $urandom, $urandom);
            end
        end
        dv  = diff_m;
        brv = borrow_m;
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    function automatic logic [31:0] ref_diff(input logic [31:0] av, input logic [31:0] bv, input int w);
        longint r;
        r = (longint'(av) - longint'(bv)) % (longint'(1) << w);
        if (r < 0) r += (longint'(1) << w);
        return 32'(r);
    endfunction

    initial begin
        logic [31:0] dv;
        logic        brv;
        int          lat;
        int          bcnt;
        bit          stable;
        int          ndone;
        logic [31:0] rd;
        logic        rb;
        int          t [3];
        int          nd;
        logic [31:0] ca [6];
        logic [31:0] cb [6];
        logic [31:0] av;
        logic [31:0] bv;
        int          w;

        vectors = 0;
        miscompares = 0;
        clk = 1'b0;
        rst = 1'b1;
        sel16 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;

        repeat (3) @(negedge clk);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_diff8", {24'd0, diff8}, 32'd0);
        check("rst_borrow8", {31'd0, borrow8}, 32'd0);
        check("rst_busy16", {31'd0, busy16}, 32'd0);
        check("rst_diff16", {16'd0, diff16}, 32'd0);
        rst = 1'b0;

        ca = '{200, 5, 0, 255, 255, 0};
        cb = '{55, 10, 1, 255, 0, 0};
        for (int i = 0; i < 6; i++) begin
            do_op(ca[i], cb[i], dv, brv, lat, bcnt, stable);
            check("corner_diff", dv, ref_diff(ca[i], cb[i], 8));
            check("corner_borrow", {31'd0, brv}, {31'd0, ca[i] < cb[i]});
            check("corner_latency", lat, 9);
            check("corner_busy_cycles", bcnt, 9);
            check("corner_diff_hidden", {31'd0, stable}, 32'd1);
        end
        do_op(200, 55, dv, brv, lat, bcnt, stable);
        check("fixed_200_55", dv, 32'd145);
        @(negedge clk);
        check("idle_after_done", {31'd0, busy_m}, 32'd0);

        // start pulses during SHIFT and DONE must be ignored
        @(negedge clk);
        drive(1'b1, 100, 1);
        ndone = 0; rd = '0; rb = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done_m) begin
                ndone++;
                rd = diff_m;
                rb = borrow_m;
            end
            if (c >= 11) check("immune_idle", {31'd0, busy_m}, 32'd0);
            drive((c == 3 || c == 9), 7, 9);
        end
        drive(1'b0, 0, 0);
        check("immune_ndone", ndone, 1);
        check("immune_diff", rd, 32'd99);
        check("immune_borrow", {31'd0, rb}, 32'd0);
        check("immune_hold", diff_m, 32'd99);

        // reset in the middle of an operation
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_clears_diff", diff_m, 32'd0);
        drive(1'b1, 50, 20);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(1'b0, 50, 20);
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy_m}, 32'd0);
        check("midrst_done", {31'd0, done_m}, 32'd0);
        check("midrst_diff", diff_m, 32'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_m) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_diff_hold", diff_m, 32'd0);
        do_op(50, 20, dv, brv, lat, bcnt, stable);
        check("after_rst_diff", dv, 32'd30);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 9, 3);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 9, 3);
        check("rst_priority_busy", {31'd0, busy_m}, 32'd0);
        @(negedge clk);
        check("rst_priority_busy2", {31'd0, busy_m}, 32'd0);

        // back-to-back operations with start held high
        @(negedge clk);
        drive(1'b1, 77, 33);
        t = '{0, 0, 0};
        nd = 0;
        for (int c = 1; c <= 40 && nd < 3; c++) begin
            @(negedge clk);
            if (done_m) begin
                t[nd] = c;
                nd++;
                check("tp_diff", diff_m, 32'd44);
            end
        end
        drive(1'b0, 0, 0);
        check("tp_count", nd, 3);
        check("tp_first", t[0], 9);
        check("tp_period1", t[1] - t[0], 10);
        check("tp_period2", t[2] - t[1], 10);
        repeat (3) @(negedge clk);
        check("tp_idle", {31'd0, busy_m}, 32'd0);

        // random regression at both widths
        for (int k = 0; k < 2; k++) begin
            sel16 = (k == 1);
            w = sel16 ? 16 : 8;
            for (int i = 0; i < 1000; i++) begin
                av = $urandom & ((32'd1 << w) - 1);
                bv = $urandom & ((32'd1 << w) - 1);
                if (i % 50 == 0) bv = av;
                do_op(av, bv, dv, brv, lat, bcnt, stable);
                check("rand_diff", dv, ref_diff(av, bv, w));
                check("rand_borrow", {31'd0, brv}, {31'd0, av < bv});
                if (i % 100 == 0) check("rand_latency", lat, w + 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
